// File: rtl/split_target_pkg.sv
// Shared types and defaults for the split-transaction serial target.
package split_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    SPLIT_WAIT,
    SPLIT_REQ,
    RDATA
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_ADDR_WIDTH    = 12;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_MEM_DEPTH     = 256;
  localparam int DEF_SPLIT_LATENCY = 8;

endpackage

// File: rtl/split_target_mem.sv
// Storage array for the split target: synchronous write, registered 1-cycle read.
module split_target_mem #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem_array[addr] <= wdata;
    if (re) rdata_reg <= mem_array[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/split_target_responder.sv
// Serial-bus target with split reads; split handshake enabled by SPLIT_TARGET_SPLIT_EN.
module split_target_responder
  import split_target_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter int SPLIT_LATENCY = DEF_SPLIT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tgt_mode,
  input  logic                  tgt_addr_in,
  input  logic                  tgt_addr_valid,
  input  logic                  tgt_data_in,
  input  logic                  tgt_data_in_valid,
  output logic                  tgt_ready,
  output logic                  tgt_ack,
  output logic                  split_ack,
  output logic                  split_req,
  input  logic                  split_grant,
  output logic                  tgt_data_out,
  output logic                  tgt_data_out_valid,
  output logic [DATA_WIDTH-1:0] last_write
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_MAX = (MAX_AD > SPLIT_LATENCY) ? MAX_AD : SPLIT_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef SPLIT_TARGET_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
  logic grant_eff;
  assign grant_eff = split_grant;
`else
  localparam bit SPLIT_EN = 1'b0;
  logic grant_eff;
  logic grant_unused;
  assign grant_eff    = 1'b0;
  assign grant_unused = split_grant;
`endif

  state_t                state_reg;
  logic                  mode_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rword_reg, rdata, load_word, last_write_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  tgt_ack_reg, split_ack_reg, split_req_reg;
  logic                  data_out_reg, data_out_valid_reg;
  logic                  cur_mode, addr_last, rd_en, mem_we;
  logic [IDX_W-1:0]      mem_addr;

  // Serial shifters fill from the MSB so bit 0 lands at the LSB after the last shift.
  if (ADDR_WIDTH == 1) begin : g_addr_1
    assign addr_next = tgt_addr_in;
  end else begin : g_addr_n
    assign addr_next = {tgt_addr_in, addr_reg[ADDR_WIDTH-1:1]};
  end
  if (DATA_WIDTH == 1) begin : g_data_1
    assign wdata_next = tgt_data_in;
  end else begin : g_data_n
    assign wdata_next = {tgt_data_in, wdata_reg[DATA_WIDTH-1:1]};
  end

  assign cur_mode  = (state_reg == IDLE) ? tgt_mode : mode_reg;
  assign addr_last = (state_reg == IDLE) ? (ADDR_WIDTH == 1)
                   : (state_reg == ADDR) && (cnt_reg == CNT_W'(ADDR_WIDTH - 1));
  // Launch the read as the last address bit lands so the word is ready in the first wait cycle.
  assign rd_en     = tgt_addr_valid && addr_last && (cur_mode == MODE_READ);
  assign mem_we    = (state_reg == WRITE);
  assign mem_addr  = mem_we ? addr_reg[IDX_W-1:0] : addr_next[IDX_W-1:0];
  assign load_word = (state_reg == SPLIT_WAIT && cnt_reg == '0) ? rdata : rword_reg;

  split_target_mem #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (rd_en),
    .addr  (mem_addr),
    .wdata (wdata_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      mode_reg           <= MODE_READ;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      rword_reg          <= '0;
      last_write_reg     <= '0;
      cnt_reg            <= '0;
      tgt_ack_reg        <= 1'b0;
      split_ack_reg      <= 1'b0;
      split_req_reg      <= 1'b0;
      data_out_reg       <= 1'b0;
      data_out_valid_reg <= 1'b0;
    end else begin
      tgt_ack_reg   <= 1'b0;
      split_ack_reg <= 1'b0;
      case (state_reg)
        IDLE, ADDR: begin
          if (tgt_addr_valid) begin
            addr_reg <= addr_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (state_reg == IDLE) mode_reg <= tgt_mode;
            if (addr_last) begin
              cnt_reg <= '0;
              if (cur_mode == MODE_WRITE) begin
                state_reg <= WDATA;
              end else begin
                state_reg     <= SPLIT_WAIT;
                split_ack_reg <= SPLIT_EN;
              end
            end else begin
              state_reg <= ADDR;
            end
          end
        end
        WDATA: begin
          if (tgt_data_in_valid) begin
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_reg     <= '0;
              state_reg   <= WRITE;
              tgt_ack_reg <= 1'b1;
            end
          end
        end
        WRITE: begin
          last_write_reg <= wdata_reg;
          state_reg      <= IDLE;
        end
        SPLIT_WAIT: begin
          if (cnt_reg == '0) rword_reg <= rdata;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(SPLIT_LATENCY - 1)) begin
            cnt_reg <= '0;
            if (SPLIT_EN) begin
              state_reg     <= SPLIT_REQ;
              split_req_reg <= 1'b1;
            end else begin
              state_reg          <= RDATA;
              rword_reg          <= load_word >> 1;
              data_out_reg       <= load_word[0];
              data_out_valid_reg <= 1'b1;
            end
          end
        end
        SPLIT_REQ: begin
          if (grant_eff) begin
            split_req_reg      <= 1'b0;
            state_reg          <= RDATA;
            cnt_reg            <= '0;
            rword_reg          <= load_word >> 1;
            data_out_reg       <= load_word[0];
            data_out_valid_reg <= 1'b1;
          end
        end
        RDATA: begin
          if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_reg            <= '0;
            state_reg          <= IDLE;
            data_out_reg       <= 1'b0;
            data_out_valid_reg <= 1'b0;
          end else begin
            cnt_reg      <= cnt_reg + 1'b1;
            data_out_reg <= rword_reg[0];
            rword_reg    <= rword_reg >> 1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tgt_ready          = (state_reg == IDLE);
  assign tgt_ack            = tgt_ack_reg;
  assign split_ack          = split_ack_reg;
  assign split_req          = split_req_reg;
  assign tgt_data_out       = data_out_reg;
  assign tgt_data_out_valid = data_out_valid_reg;
  assign last_write         = last_write_reg;

endmodule

// File: tb/tb_split_target_responder.sv
// Directed plus randomized bench for split_target_responder against a word-level memory model.
module tb_split_target_responder;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int LAT   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tgt_mode = 1'b0;
  logic          tgt_addr_in = 1'b0;
  logic          tgt_addr_valid = 1'b0;
  logic          tgt_data_in = 1'b0;
  logic          tgt_data_in_valid = 1'b0;
  logic          split_grant = 1'b0;
  logic          tgt_ready, tgt_ack, split_ack, split_req;
  logic          tgt_data_out, tgt_data_out_valid;
  logic [DW-1:0] last_write;

  always #5 clk = ~clk;

  split_target_responder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_DEPTH     (DEPTH),
    .SPLIT_LATENCY (LAT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .tgt_mode           (tgt_mode),
    .tgt_addr_in        (tgt_addr_in),
    .tgt_addr_valid     (tgt_addr_valid),
    .tgt_data_in        (tgt_data_in),
    .tgt_data_in_valid  (tgt_data_in_valid),
    .tgt_ready          (tgt_ready),
    .tgt_ack            (tgt_ack),
    .split_ack          (split_ack),
    .split_req          (split_req),
    .split_grant        (split_grant),
    .tgt_data_out       (tgt_data_out),
    .tgt_data_out_valid (tgt_data_out_valid),
    .last_write         (last_write)
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW-1:0] last_write_model = '0;
  int            written_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tgt_mode = 1'b0; tgt_addr_in = 1'b0; tgt_addr_valid = 1'b0;
    tgt_data_in = 1'b0; tgt_data_in_valid = 1'b0; split_grant = 1'b0;
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    last_write_model = '0;
    check("rst_split_req", split_req, 0);
    check("rst_outputs", {tgt_ack, split_ack, tgt_data_out, tgt_data_out_valid}, 0);
    check("rst_last_write", last_write, last_write_model);
    check("rst_ready", tgt_ready, 1);
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    $display("reset asserted mid-transaction");
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    check("ready_before_write", tgt_ready, 1);
    for (int i = 0; i < AW; i++) begin
      if ($urandom_range(3) == 0) begin
        tgt_data_in_valid = 1'b1; tgt_data_in = 1'($urandom_range(1));
        step();
        tgt_data_in_valid = 1'b0;
      end
      tgt_addr_valid = 1'b1; tgt_addr_in = addr[i];
      tgt_mode = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      step();
      tgt_addr_valid = 1'b0;
      if (i == 0) check("ready_low_after_first_addr", tgt_ready, 0);
    end
    for (int i = 0; i < DW; i++) begin
      if ($urandom_range(3) == 0) begin
        tgt_addr_valid = 1'b1; tgt_addr_in = 1'($urandom_range(1));
        step();
        tgt_addr_valid = 1'b0;
        check("no_ack_in_wdata", tgt_ack, 0);
      end
      tgt_data_in_valid = 1'b1; tgt_data_in = data[i];
      step();
      tgt_data_in_valid = 1'b0;
    end
    check("write_ack_pulse", tgt_ack, 1);
    check("ready_low_in_write", tgt_ready, 0);
    step();
    mem_model[addr[7:0]] = data;
    last_write_model = data;
    check("write_ack_one_cycle", tgt_ack, 0);
    check("ready_after_write", tgt_ready, 1);
    check("last_write", last_write, last_write_model);
    $display("write addr=0x%03h data=0x%02h", addr, data);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int delay, input bit abort);
    logic [DW-1:0] got;
    logic [DW-1:0] exp;
    exp = mem_model[addr[7:0]];
    got = '0;
    check("ready_before_read", tgt_ready, 1);
    for (int i = 0; i < AW; i++) begin
      if ($urandom_range(3) == 0) begin
        tgt_data_in_valid = 1'b1; tgt_data_in = 1'($urandom_range(1));
        step();
        tgt_data_in_valid = 1'b0;
      end
      tgt_addr_valid = 1'b1; tgt_addr_in = addr[i];
      tgt_mode = (i == 0) ? 1'b0 : 1'($urandom_range(1));
      step();
      tgt_addr_valid = 1'b0;
    end
`ifdef SPLIT_TARGET_SPLIT_EN
    check("split_ack_pulse", split_ack, 1);
`else
    check("no_split_ack", split_ack, 0);
`endif
    check("no_valid_at_accept", tgt_data_out_valid, 0);
    // Write attempts and stray grants while waiting must all be ignored.
    for (int c = 1; c <= LAT; c++) begin
      tgt_addr_valid = 1'b1; tgt_mode = 1'b1; tgt_addr_in = 1'($urandom_range(1));
      tgt_data_in_valid = 1'b1; tgt_data_in = 1'($urandom_range(1));
      split_grant = 1'($urandom_range(1));
      step();
      clear_inputs();
      if (c < LAT) check("wait_quiet", {split_ack, split_req, tgt_data_out_valid, tgt_ack}, 0);
    end
`ifdef SPLIT_TARGET_SPLIT_EN
    check("split_req_rise", split_req, 1);
    check("no_valid_before_grant", tgt_data_out_valid, 0);
    if (abort) begin
      reset_mid();
      return;
    end
    for (int d = 0; d < delay; d++) begin
      step();
      check("split_req_held", split_req, 1);
      check("no_valid_while_req", tgt_data_out_valid, 0);
    end
    split_grant = 1'b1;
    step();
    split_grant = 1'b0;
    check("split_req_drop", split_req, 0);
`else
    check("no_split_req", split_req, 0);
    if (abort) begin
      reset_mid();
      return;
    end
`endif
    for (int i = 0; i < DW; i++) begin
      check("rdata_valid", tgt_data_out_valid, 1);
      got[i] = tgt_data_out;
      step();
    end
    check("rdata_valid_end", tgt_data_out_valid, 0);
    check("ready_after_read", tgt_ready, 1);
    check("read_data", got, exp);
    $display("read  addr=0x%03h data=0x%02h expected=0x%02h grant_delay=%0d", addr, got, exp, delay);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    idx;
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("reset_ready", tgt_ready, 1);
    check("reset_outputs", {tgt_ack, split_ack, split_req, tgt_data_out, tgt_data_out_valid}, 0);
    check("reset_last_write", last_write, 0);
    rst_n = 1'b1;
    step();

    do_write(12'h012, 8'hA5);
    written_q.push_back(8'h12);
    do_read(12'h012, 0, 1'b0);
    do_read(12'h012, 20, 1'b0);
    do_read(12'h112, 2, 1'b0);
    do_read(12'h012, 0, 1'b1);
    do_read(12'h012, 1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      if (written_q.size() < 3 || $urandom_range(1) == 0) begin
        idx = 8'($urandom_range(255));
        a   = {4'($urandom_range(15)), idx};
        do_write(a, 8'($urandom_range(255)));
        written_q.push_back(int'(idx));
      end else begin
        idx = 8'(written_q[$urandom_range(written_q.size() - 1)]);
        a   = {4'($urandom_range(15)), idx};
        do_read(a, $urandom_range(5), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
